// File: rtl/key_pio_pkg.sv
// Shared definitions for the key PIO: register offsets and the master's FSM states.
// Used by both the Avalon master RTL and the PIO-side software/behavioural model.
package key_pio_pkg;

    localparam logic [1:0] PIO_DATA     = 2'd0;
    localparam logic [1:0] PIO_IRQ_MASK = 2'd2;
    localparam logic [1:0] PIO_EDGE_CAP = 2'd3;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_A,
        RD_B,
        CLR,
        EMIT
    } state_t;

endpackage

// File: rtl/key_event_master.sv
// Avalon-MM master that services the key PIO: programs irq_mask, reads and clears
// edge_capture on irq or poll tick, and delivers the captured bitmap on a valid/ready stream.
module key_event_master
    import key_pio_pkg::*;
#(
    parameter int               KEY_W       = 4,
    parameter logic [KEY_W-1:0] IRQ_MASK    = KEY_W'(4'hF),
    parameter int               POLL_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             irq,
    output logic [1:0]       address,
    output logic             chipselect,
    output logic             write_n,
    output logic [31:0]      writedata,
    input  logic [31:0]      readdata,
    output logic             event_valid,
    input  logic             event_ready,
    output logic [KEY_W-1:0] event_keys,
    output logic [15:0]      event_count
);

    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [PW-1:0] POLL_LAST = (POLL_CYCLES > 0) ? PW'(POLL_CYCLES - 1) : '0;

    state_t            state, state_nx;
    logic [PW-1:0]     poll_cnt, poll_nx;
    logic              poll_tick;
    logic [1:0]        address_nx;
    logic              chipselect_nx, write_n_nx, event_valid_nx;
    logic [31:0]       writedata_nx;
    logic [KEY_W-1:0]  event_keys_nx;
    logic [15:0]       event_count_nx;

    // Only readdata[KEY_W-1:0] carries key bits; the rest is intentionally ignored.
    logic unused_readdata;
    assign unused_readdata = ^readdata;

    assign poll_tick = (POLL_CYCLES > 0) && (poll_cnt == POLL_LAST);

    // NOTE: every signal gets a default before the case so no latch can be inferred.
    always_comb begin
        state_nx       = state;
        event_keys_nx  = event_keys;
        event_count_nx = event_count;
        poll_nx        = '0;

        case (state)
            INIT:    if (chipselect && !write_n) state_nx = IDLE;
            IDLE:    if (irq || poll_tick) state_nx = RD_A;
            RD_A:    state_nx = RD_B;
            RD_B: begin
                event_keys_nx = readdata[KEY_W-1:0];
                state_nx      = CLR;
            end
            CLR:     state_nx = (|event_keys) ? EMIT : IDLE;
            EMIT: begin
                if (event_valid && event_ready) begin
                    event_count_nx = event_count + 16'd1;
                    state_nx       = IDLE;
                end
            end
            default: state_nx = INIT;
        endcase

        if (POLL_CYCLES > 0 && state == IDLE && state_nx == IDLE)
            poll_nx = poll_cnt + 1'b1;

        // Outputs are decoded from the next state so the flops present them during that state.
        address_nx     = PIO_EDGE_CAP;
        chipselect_nx  = 1'b0;
        write_n_nx     = 1'b1;
        writedata_nx   = '0;
        event_valid_nx = 1'b0;
        case (state_nx)
            INIT: begin
                address_nx    = PIO_IRQ_MASK;
                chipselect_nx = 1'b1;
                write_n_nx    = 1'b0;
                writedata_nx  = 32'(IRQ_MASK);
            end
            RD_A, RD_B: chipselect_nx = 1'b1;
            CLR: begin
                chipselect_nx = 1'b1;
                write_n_nx    = 1'b0;
            end
            EMIT:    event_valid_nx = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= INIT;
            address     <= '0;
            chipselect  <= 1'b0;
            write_n     <= 1'b1;
            writedata   <= '0;
            event_valid <= 1'b0;
            event_keys  <= '0;
            event_count <= '0;
            poll_cnt    <= '0;
        end else begin
            state       <= state_nx;
            address     <= address_nx;
            chipselect  <= chipselect_nx;
            write_n     <= write_n_nx;
            writedata   <= writedata_nx;
            event_valid <= event_valid_nx;
            event_keys  <= event_keys_nx;
            event_count <= event_count_nx;
            poll_cnt    <= poll_nx;
        end
    end

endmodule
